// File: rtl/cam_sccb_config.sv
// Camera power-up sequencer: pulses cam_reset_n, then writes an external register table over SCCB.
// One write takes 117 quarter-bits plus a 2-cycle table fetch; start is ignored while busy.
module cam_sccb_config #(
  parameter int         CLK_DIV    = 4,
  parameter logic [7:0] DEV_ADDR   = 8'h42,
  parameter int         ADDR_W     = 8,
  parameter int         RST_HOLD   = 16,
  parameter int         PWRUP_WAIT = 64,
  parameter int         DELAY_UNIT = 32,
  parameter bit         CHECK_ACK  = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [15:0]       rom_data,
  output logic              sioc,
  output logic              siod_o,
  output logic              siod_oe,
  input  logic              siod_i,
  output logic              cam_reset_n,
  output logic              cam_enable,
  output logic              busy,
  output logic              done,
  output logic              error
);

  typedef enum logic [3:0] {
    S_IDLE, S_HOLD, S_WAKE, S_FETCH, S_DLY, S_START, S_BITS, S_STOP, S_GAP, S_FIN
  } state_t;

  state_t      r_state;
  logic [31:0] r_cnt;
  logic [31:0] r_qcnt;
  logic [1:0]  r_q;
  logic        r_fph;
  logic [4:0]  r_bit;
  logic [3:0]  r_b9;
  logic [26:0] r_sh;

  logic        w_qstate;
  logic        w_qend;
  logic        w_last;
  logic        w_ent_end;
  logic        w_ent_dly;
  logic        w_adv;
  logic [31:0] w_dly;

  assign w_qstate  = (r_state == S_START) || (r_state == S_BITS) ||
                     (r_state == S_STOP)  || (r_state == S_GAP);
  assign w_qend    = (r_qcnt == 32'(CLK_DIV - 1));
  assign w_last    = (rom_addr == {ADDR_W{1'b1}});
  assign w_ent_end = (rom_data == 16'hFFFF);
  assign w_ent_dly = (rom_data[15:8] == 8'hFE);
  assign w_dly     = 32'(rom_data[7:0]) * 32'(DELAY_UNIT);

  // Every path that finishes a table entry funnels through here, so the overrun check lives in one place.
  assign w_adv = ((r_state == S_FETCH) && r_fph && w_ent_dly && (rom_data[7:0] == 8'd0)) ||
                 ((r_state == S_DLY) && (r_cnt == 32'd0)) ||
                 ((r_state == S_GAP) && w_qend && (r_q == 2'd3));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_qcnt      <= '0;
      r_q         <= '0;
      r_fph       <= 1'b0;
      r_bit       <= '0;
      r_b9        <= '0;
      r_sh        <= '0;
      rom_addr    <= '0;
      sioc        <= 1'b1;
      siod_o      <= 1'b1;
      siod_oe     <= 1'b0;
      cam_reset_n <= 1'b0;
      cam_enable  <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      error       <= 1'b0;
    end else begin
      if (w_qstate) begin
        r_qcnt <= w_qend ? 32'd0 : r_qcnt + 32'd1;
        if (w_qend) r_q <= r_q + 2'd1;
      end

      case (r_state)
        S_IDLE: begin
          if (start) begin
            done        <= 1'b0;
            error       <= 1'b0;
            busy        <= 1'b1;
            cam_enable  <= 1'b0;
            cam_reset_n <= 1'b0;
            rom_addr    <= '0;
            r_cnt       <= '0;
            r_state     <= S_HOLD;
          end
        end

        S_HOLD: begin
          if (r_cnt == 32'(RST_HOLD - 1)) begin
            r_cnt       <= '0;
            cam_reset_n <= 1'b1;
            r_state     <= S_WAKE;
          end else begin
            r_cnt <= r_cnt + 32'd1;
          end
        end

        S_WAKE: begin
          if (r_cnt == 32'(PWRUP_WAIT - 1)) begin
            r_cnt   <= '0;
            r_fph   <= 1'b0;
            r_state <= S_FETCH;
          end else begin
            r_cnt <= r_cnt + 32'd1;
          end
        end

        // First cycle presents the address, second consumes the registered table word.
        S_FETCH: begin
          if (!r_fph) begin
            r_fph <= 1'b1;
          end else begin
            r_fph <= 1'b0;
            if (w_ent_end) begin
              busy       <= 1'b0;
              done       <= 1'b1;
              cam_enable <= 1'b1;
              r_state    <= S_FIN;
            end else if (w_ent_dly) begin
              if (rom_data[7:0] != 8'd0) begin
                r_cnt   <= w_dly - 32'd1;
                r_state <= S_DLY;
              end
            end else begin
              r_sh    <= {DEV_ADDR, 1'b1, rom_data[15:8], 1'b1, rom_data[7:0], 1'b1};
              r_qcnt  <= '0;
              r_q     <= '0;
              sioc    <= 1'b1;
              siod_o  <= 1'b1;
              siod_oe <= 1'b1;
              r_state <= S_START;
            end
          end
        end

        S_DLY: begin
          if (r_cnt != 32'd0) r_cnt <= r_cnt - 32'd1;
        end

        S_START: begin
          if (w_qend) begin
            if (r_q == 2'd0) begin
              siod_o <= 1'b0;
            end else begin
              r_q     <= '0;
              r_bit   <= '0;
              r_b9    <= '0;
              sioc    <= 1'b0;
              siod_o  <= r_sh[26];
              siod_oe <= 1'b1;
              r_sh    <= r_sh << 1;
              r_state <= S_BITS;
            end
          end
        end

        S_BITS: begin
          if (w_qend) begin
            case (r_q)
              2'd1: sioc <= 1'b1;
              2'd2: begin
                if (CHECK_ACK && (r_b9 == 4'd8) && siod_i) error <= 1'b1;
              end
              2'd3: begin
                sioc <= 1'b0;
                if (r_bit == 5'd26) begin
                  siod_o  <= 1'b0;
                  siod_oe <= 1'b1;
                  r_state <= S_STOP;
                end else begin
                  r_bit   <= r_bit + 5'd1;
                  r_b9    <= (r_b9 == 4'd8) ? 4'd0 : r_b9 + 4'd1;
                  siod_o  <= r_sh[26];
                  // The slave owns SIOD during every 9th bit.
                  siod_oe <= (r_b9 != 4'd7);
                  r_sh    <= r_sh << 1;
                end
              end
              default: ;
            endcase
          end
        end

        S_STOP: begin
          if (w_qend) begin
            case (r_q)
              2'd0: sioc <= 1'b1;
              2'd1: siod_o <= 1'b1;
              default: begin
                r_q     <= '0;
                siod_oe <= 1'b0;
                r_state <= S_GAP;
              end
            endcase
          end
        end

        S_GAP: ;

        S_FIN: r_state <= S_IDLE;

        default: r_state <= S_IDLE;
      endcase

      if (w_adv) begin
        if (w_last) begin
          error      <= 1'b1;
          busy       <= 1'b0;
          done       <= 1'b1;
          cam_enable <= 1'b1;
          r_state    <= S_FIN;
        end else begin
          rom_addr <= ADDR_W'(rom_addr + 1'b1);
          r_fph    <= 1'b0;
          r_state  <= S_FETCH;
        end
      end
    end
  end

endmodule

// File: doc/cam_sccb_config.md
Name: cam_sccb_config

Overview:
Power-up and register-configuration sequencer for the camera capture path. It drives the camera reset pin, then walks an external register table and writes each entry over the SCCB 3-phase write protocol on SIOC/SIOD. When the table completes it raises cam_enable, which gates the capture block. It takes over ownership of SIOC/SIOD from the capture datapath.

Parameters:
CLK_DIV, 4, clk cycles per SCCB quarter-bit; must be ≥ 1.
DEV_ADDR, 8'h42, SCCB write ID byte.
ADDR_W, 8, table address width.
RST_HOLD, 16, clk cycles cam_reset_n is held low.
PWRUP_WAIT, 64, clk cycles between reset release and the first write.
DELAY_UNIT, 32, clk cycles per count of a delay entry.
CHECK_ACK, 0, 1 = sample the 9th bit and flag NACK.

Ports:
clk  in  1  system clock; all logic on the rising edge.
rst  in  1  asynchronous, active-low reset.
start  in  1  one-cycle pulse that begins the sequence; ignored while busy=1.
rom_addr  out  ADDR_W  table address.
rom_data  in  16  {reg[15:8], val[7:0]}; valid one clk after rom_addr changes.
sioc  out  1  SCCB clock.
siod_o  out  1  SCCB data out.
siod_oe  out  1  SIOD output enable; 0 releases the line.
siod_i  in  1  SCCB data in, used only for the ACK sample.
cam_reset_n  out  1  camera hardware reset, active-low.
cam_enable  out  1  enable to the capture block.
busy  out  1  sequence in progress.
done  out  1  sticky; table finished.
error  out  1  sticky; NACK seen or table overrun.

Behaviour:
- Reset values: sioc=1, siod_o=1, siod_oe=0, cam_reset_n=0, cam_enable=0, busy=0, done=0, error=0, rom_addr=0, state IDLE, all counters 0.
- Reset asserted mid-transaction aborts immediately. No STOP condition is issued.
- States and transitions:
  - IDLE: on start, clear done/error, set busy=1, set rom_addr=0, go to HOLD.
  - HOLD: cam_reset_n=0 for RST_HOLD cycles, then go to WAKE.
  - WAKE: cam_reset_n=1, wait PWRUP_WAIT cycles, then go to FETCH.
  - FETCH: 2 cycles (address, then latch rom_data). Decode the latched entry:
    - {FF,FF}: end marker, go to FIN.
    - {FE,n}: go to DLY.
    - anything else: go to START.
  - DLY: wait n*DELAY_UNIT cycles, increment rom_addr, go to FETCH. n=0 gives zero wait.
  - START (2 quarters): q0 sioc=1, siod_o=1, oe=1; q1 siod_o=0.
  - BITS: 27 bits = DEV_ADDR, reg, val, each byte MSB first followed by a 9th bit. Each bit is 4 quarters:
    - q0–q1: sioc=0; siod_o is updated at the start of q0.
    - q2–q3: sioc=1.
    - 9th bit of each byte: siod_oe=0 for all 4 quarters. If CHECK_ACK=1, sample siod_i at the start of q3; a 1 sets error. The sequence continues regardless.
  - STOP (3 quarters): q0 sioc=0, siod_o=0, oe=1; q1 sioc=1; q2 siod_o=1.
  - GAP: 4 quarters, bus idle high, oe=0. Then increment rom_addr and go to FETCH.
  - FIN: busy=0, done=1, cam_enable=1, go to IDLE. cam_enable stays 1 until the next accepted start or reset.
- Timing of one write: 2+108+3+4 = 117 quarters, i.e. 117*CLK_DIV cycles. With FETCH, write-to-write is 117*CLK_DIV+2 cycles (470 at CLK_DIV=4).
- Overrun: if rom_addr = 2^ADDR_W−1 and that entry is not the end marker, complete that entry, then set error=1 and go to FIN. rom_addr never wraps.
- An accepted start drops cam_enable on the next cycle. A start arriving in the same cycle as FIN is ignored.
- Quarter counter counts 0..CLK_DIV−1. All SIOC/SIOD changes occur only on quarter boundaries and are driven from registered outputs.

Test Plan:
- Table {12,80},{FF,FF}, CLK_DIV=4, start:
  - cam_reset_n is low for 16 clks, then 64 idle clks.
  - Exactly 27 SIOC rising edges occur; decoded bytes are 42, 12, 80.
  - done=1 and cam_enable=1 occur 470 clks after the first fetch.
- Three register entries then end marker: 3 STOP conditions are seen, rom_addr ends at 3, error=0.
- Table {FE,02},{11,01},{FF,FF}: the gap between FETCH of entry 0 and START of entry 1 is 64+2 clks.
- CHECK_ACK=1 with siod_i held 1: error=1, done=1, and all 27 bits are still sent.
- ADDR_W=2 with no end marker: 4 writes occur, then error=1, done=1, rom_addr=3.
- rst asserted during bit 10:
  - Outputs go to their reset values at once.
  - A following start replays the sequence from entry 0.
  - A start pulse while busy=1 causes no change.
